// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem writeback path.
//   X_ID_WIDTH  width of the X-interface instruction id
//   FLEN        floating-point register width
//   wb_entry_t  one writeback result {id, data, rd, fpr_we, xreg_we}
//   wb_src_e    writeback grant source
package fpu_ss_pkg;

    localparam int unsigned X_ID_WIDTH = 4;
    localparam int unsigned FLEN       = 32;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [FLEN-1:0]       data;
        logic [4:0]            rd;
        logic                  fpr_we;
        logic                  xreg_we;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WbNone,
        WbMem,
        WbFpu,
        WbCsr
    } wb_src_e;

endpackage

// File: rtl/fpu_ss_wb_fifo.sv
// Memory-result FIFO for the writeback arbiter.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (clears pointers and count)
//   push_i, data_i write one entry
//   pop_i          remove the head entry (ignored when empty)
//   head_o         current head entry
//   empty_o/full_o occupancy flags
//   count_o        number of stored entries
module fpu_ss_wb_fifo
    import fpu_ss_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  wb_entry_t        data_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        // A push into a full FIFO is only accepted when the head leaves in the same cycle.
        do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/fpu_ss_wb_arbiter.sv
// Writeback scheduler for the FPU subsystem. Shares the X result channel and the FP
// register-file write port between FPnew, CSR and memory results. Memory results
// cannot be stalled, so memory issue is credit-gated and results are buffered.
// Ports:
//   clk_i, rst_i                          clock, synchronous active-high reset
//   fpu_valid_i/fpu_ready_o/fpu_res_i      FPnew result handshake (ready is the grant)
//   csr_valid_i/csr_ready_o/csr_res_i      CSR result handshake (ready is the grant)
//   mem_issue_i/mem_issue_allow_o          memory request issued / may be issued
//   mem_valid_i/mem_res_i                  memory result (no back-pressure)
//   fpr_we_o/fpr_waddr_o/fpr_wdata_o       FP register-file write port (grant cycle)
//   x_result_valid_o/ready_i/x_result_o    registered X result channel
//   perf_fpu_stall_o                       FPU stall cycle counter
// Build option: FPU_SS_WB_PERF_EN enables the saturating stall counter; otherwise the
// counter output is tied to zero.
module fpu_ss_wb_arbiter
    import fpu_ss_pkg::*;
#(
    parameter int unsigned MEM_OUTSTANDING = 2,
    parameter bit          RR_EN           = 1'b1,
    parameter int unsigned PERF_W          = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fpu_valid_i,
    output logic              fpu_ready_o,
    input  wb_entry_t         fpu_res_i,
    input  logic              csr_valid_i,
    output logic              csr_ready_o,
    input  wb_entry_t         csr_res_i,
    input  logic              mem_issue_i,
    output logic              mem_issue_allow_o,
    input  logic              mem_valid_i,
    input  wb_entry_t         mem_res_i,
    output logic              fpr_we_o,
    output logic [4:0]        fpr_waddr_o,
    output logic [FLEN-1:0]   fpr_wdata_o,
    output logic              x_result_valid_o,
    input  logic              x_result_ready_i,
    output wb_entry_t         x_result_o,
    output logic [PERF_W-1:0] perf_fpu_stall_o
);

    localparam int unsigned CNT_W = $clog2(MEM_OUTSTANDING + 1);

    logic             x_valid_q, x_valid_d;
    wb_entry_t        x_res_q, x_res_d;
    logic             rr_csr_next_q, rr_csr_next_d;
    logic [CNT_W-1:0] credits_q, credits_d;

    logic             stage_free;
    wb_src_e          grant;
    wb_entry_t        sel_entry;
    logic [CNT_W-1:0] in_flight;

    logic             fifo_push;
    logic             fifo_pop;
    wb_entry_t        fifo_head;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;

    fpu_ss_wb_fifo #(
        .DEPTH (MEM_OUTSTANDING)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (mem_res_i),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    always_comb begin
        stage_free = !x_valid_q || x_result_ready_i;
        grant      = WbNone;
        if (stage_free) begin
            if (!fifo_empty) begin
                grant = WbMem;
            end else if (fpu_valid_i && csr_valid_i) begin
                grant = (RR_EN && rr_csr_next_q) ? WbCsr : WbFpu;
            end else if (fpu_valid_i) begin
                grant = WbFpu;
            end else if (csr_valid_i) begin
                grant = WbCsr;
            end
        end

        case (grant)
            WbMem:   sel_entry = fifo_head;
            WbFpu:   sel_entry = fpu_res_i;
            WbCsr:   sel_entry = csr_res_i;
            default: sel_entry = '0;
        endcase

        fpu_ready_o = (grant == WbFpu);
        csr_ready_o = (grant == WbCsr);
        fifo_pop    = (grant == WbMem);

        fpr_we_o    = (grant != WbNone) && sel_entry.fpr_we;
        fpr_waddr_o = sel_entry.rd;
        fpr_wdata_o = sel_entry.data;

        x_valid_d = x_valid_q;
        x_res_d   = x_res_q;
        if (stage_free) begin
            x_valid_d = (grant != WbNone);
            if (grant != WbNone) begin
                x_res_d = sel_entry;
            end
        end

        rr_csr_next_d = rr_csr_next_q;
        if (grant == WbFpu) begin
            rr_csr_next_d = 1'b1;
        end else if (grant == WbCsr) begin
            rr_csr_next_d = 1'b0;
        end

        // Results with no matching request in flight are stale (e.g. issued before a
        // reset) and are dropped rather than pushed.
        in_flight = credits_q - fifo_count;
        fifo_push = mem_valid_i && (in_flight != '0);

        credits_d = credits_q;
        if (mem_issue_i && !fifo_pop) begin
            credits_d = credits_q + CNT_W'(1);
        end else if (!mem_issue_i && fifo_pop) begin
            credits_d = credits_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_valid_q     <= 1'b0;
            x_res_q       <= '0;
            rr_csr_next_q <= 1'b0;
            credits_q     <= '0;
        end else begin
            x_valid_q     <= x_valid_d;
            x_res_q       <= x_res_d;
            rr_csr_next_q <= rr_csr_next_d;
            credits_q     <= credits_d;
        end
    end

    assign mem_issue_allow_o = (credits_q < CNT_W'(MEM_OUTSTANDING));
    assign x_result_valid_o  = x_valid_q;
    assign x_result_o        = x_res_q;

`ifdef FPU_SS_WB_PERF_EN
    logic [PERF_W-1:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (fpu_valid_i && !fpu_ready_o && (perf_q != '1)) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_fpu_stall_o = perf_q;
`else
    assign perf_fpu_stall_o = '0;
`endif

    a_issue_allowed: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_issue_i |-> mem_issue_allow_o);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        fifo_push |-> (!fifo_full || fifo_pop));

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
module tb_fpu_ss_wb_arbiter;
    import fpu_ss_pkg::*;

    localparam int MEM_OUT = 2;
    localparam int PERF_W  = 32;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              fpu_valid_i, csr_valid_i, mem_issue_i, mem_valid_i, x_result_ready_i;
    wb_entry_t         fpu_res_i, csr_res_i, mem_res_i;
    logic              fpu_ready_o, csr_ready_o, mem_issue_allow_o, fpr_we_o, x_result_valid_o;
    logic [4:0]        fpr_waddr_o;
    logic [FLEN-1:0]   fpr_wdata_o;
    wb_entry_t         x_result_o;
    logic [PERF_W-1:0] perf_fpu_stall_o;

    logic              fp_fpu_ready, fp_csr_ready, fp_allow, fp_fpr_we, fp_x_valid;
    logic [4:0]        fp_waddr;
    logic [FLEN-1:0]   fp_wdata;
    wb_entry_t         fp_x_res;
    logic [PERF_W-1:0] fp_perf;

    always #5 clk = ~clk;

    fpu_ss_wb_arbiter #(.MEM_OUTSTANDING(MEM_OUT), .RR_EN(1'b1), .PERF_W(PERF_W)) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o), .fpu_res_i(fpu_res_i),
        .csr_valid_i(csr_valid_i), .csr_ready_o(csr_ready_o), .csr_res_i(csr_res_i),
        .mem_issue_i(mem_issue_i), .mem_issue_allow_o(mem_issue_allow_o),
        .mem_valid_i(mem_valid_i), .mem_res_i(mem_res_i),
        .fpr_we_o(fpr_we_o), .fpr_waddr_o(fpr_waddr_o), .fpr_wdata_o(fpr_wdata_o),
        .x_result_valid_o(x_result_valid_o), .x_result_ready_i(x_result_ready_i),
        .x_result_o(x_result_o), .perf_fpu_stall_o(perf_fpu_stall_o)
    );

    // Fixed-priority variant fed with identical stimulus.
    fpu_ss_wb_arbiter #(.MEM_OUTSTANDING(MEM_OUT), .RR_EN(1'b0), .PERF_W(PERF_W)) u_dut_fp (
        .clk_i(clk), .rst_i(rst_i),
        .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fp_fpu_ready), .fpu_res_i(fpu_res_i),
        .csr_valid_i(csr_valid_i), .csr_ready_o(fp_csr_ready), .csr_res_i(csr_res_i),
        .mem_issue_i(mem_issue_i), .mem_issue_allow_o(fp_allow),
        .mem_valid_i(mem_valid_i), .mem_res_i(mem_res_i),
        .fpr_we_o(fp_fpr_we), .fpr_waddr_o(fp_waddr), .fpr_wdata_o(fp_wdata),
        .x_result_valid_o(fp_x_valid), .x_result_ready_i(x_result_ready_i),
        .x_result_o(fp_x_res), .perf_fpu_stall_o(fp_perf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: output slot, memory result queue, credit count, RR history.
    bit        m_valid;
    wb_entry_t m_out;
    wb_entry_t m_q[$];
    int        m_credits;
    bit        m_fpu_won_last;
    longint    m_perf;
    wb_src_e   m_grant;
    wb_entry_t m_sel;
    bit        m_free;

    task automatic model_reset();
        m_valid        = 1'b0;
        m_out          = '0;
        m_q.delete();
        m_credits      = 0;
        m_fpu_won_last = 1'b0;
        m_perf         = 0;
    endtask

    function automatic wb_entry_t mk(input int id, input logic [31:0] data, input int rd, input bit we);
        wb_entry_t e;
        e.id      = X_ID_WIDTH'(id);
        e.data    = data;
        e.rd      = 5'(rd);
        e.fpr_we  = we;
        e.xreg_we = 1'b1;
        return e;
    endfunction

    function automatic wb_entry_t rnd_entry();
        wb_entry_t e;
        e.id      = X_ID_WIDTH'($urandom());
        e.data    = $urandom();
        e.rd      = 5'($urandom());
        e.fpr_we  = 1'($urandom());
        e.xreg_we = 1'($urandom());
        return e;
    endfunction

    task automatic idle();
        rst_i = 1'b0; fpu_valid_i = 1'b0; csr_valid_i = 1'b0; mem_issue_i = 1'b0;
        mem_valid_i = 1'b0; mem_res_i = '0; x_result_ready_i = 1'b1;
        fpu_res_i = '0; csr_res_i = '0;
    endtask

    // Mid-cycle: work out what the model expects this cycle and compare every output.
    task automatic settle();
        @(negedge clk);
        m_free  = !m_valid || x_result_ready_i;
        m_grant = WbNone;
        if (m_free) begin
            if (m_q.size() > 0)                   m_grant = WbMem;
            else if (fpu_valid_i && csr_valid_i)  m_grant = m_fpu_won_last ? WbCsr : WbFpu;
            else if (fpu_valid_i)                 m_grant = WbFpu;
            else if (csr_valid_i)                 m_grant = WbCsr;
        end
        case (m_grant)
            WbMem:   m_sel = m_q[0];
            WbFpu:   m_sel = fpu_res_i;
            WbCsr:   m_sel = csr_res_i;
            default: m_sel = '0;
        endcase
        check("x_valid", 64'(x_result_valid_o), 64'(m_valid));
        if (m_valid) check("x_payload", 64'(x_result_o), 64'(m_out));
        check("fpu_ready", 64'(fpu_ready_o), 64'(m_grant == WbFpu));
        check("csr_ready", 64'(csr_ready_o), 64'(m_grant == WbCsr));
        check("mem_allow", 64'(mem_issue_allow_o), 64'(m_credits < MEM_OUT));
        check("fpr_we", 64'(fpr_we_o), 64'(m_grant != WbNone && m_sel.fpr_we));
        if (m_grant != WbNone && m_sel.fpr_we) begin
            check("fpr_waddr", 64'(fpr_waddr_o), 64'(m_sel.rd));
            check("fpr_wdata", 64'(fpr_wdata_o), 64'(m_sel.data));
        end
`ifdef FPU_SS_WB_PERF_EN
        check("perf", 64'(perf_fpu_stall_o), 64'(m_perf));
`else
        check("perf", 64'(perf_fpu_stall_o), 64'd0);
`endif
        if (fpu_valid_i) check("fp_csr_ready", 64'(fp_csr_ready), 64'd0);
    endtask

    // Apply this cycle's effects to the model, then move past the clock edge.
    task automatic advance();
        int  inflight;
        if (rst_i) begin
            model_reset();
        end else begin
            inflight = m_credits - m_q.size();
            if (m_free) begin
                m_valid = (m_grant != WbNone);
                if (m_grant != WbNone) m_out = m_sel;
            end
            if (m_grant == WbMem) void'(m_q.pop_front());
            if (mem_valid_i && inflight > 0) m_q.push_back(mem_res_i);
            m_credits = m_credits + int'(mem_issue_i) - int'(m_grant == WbMem);
            if (m_grant == WbFpu) m_fpu_won_last = 1'b1;
            else if (m_grant == WbCsr) m_fpu_won_last = 1'b0;
            if (fpu_valid_i && m_grant != WbFpu && m_perf < 64'hFFFF_FFFF) m_perf++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    wb_entry_t held;
    logic [PERF_W-1:0] perf0;
    int pend[$];

    initial begin
        idle();
        rst_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Reset state
        settle();
        check("rst_x_valid", 64'(x_result_valid_o), 64'd0);
        check("rst_x_res", 64'(x_result_o), 64'd0);
        check("rst_allow", 64'(mem_issue_allow_o), 64'd1);
        check("rst_perf", 64'(perf_fpu_stall_o), 64'd0);
        advance();

        // 1: single FPU result, latency 1
        fpu_valid_i = 1'b1;
        fpu_res_i   = mk(3, 32'h3F80_0000, 5, 1'b1);
        settle();
        check("t1_fpr_we", 64'(fpr_we_o), 64'd1);
        check("t1_waddr", 64'(fpr_waddr_o), 64'd5);
        advance();
        fpu_valid_i = 1'b0;
        settle();
        check("t1_x_valid", 64'(x_result_valid_o), 64'd1);
        check("t1_x_id", 64'(x_result_o.id), 64'd3);
        advance();

        // 2: FPU and CSR contend; FPU won last, so CSR goes first then alternation
        fpu_valid_i = 1'b1;
        csr_valid_i = 1'b1;
        perf0 = perf_fpu_stall_o;
        for (int i = 0; i < 4; i++) begin
            fpu_res_i = rnd_entry();
            csr_res_i = rnd_entry();
            settle();
            check("t2_rr_fpu", 64'(fpu_ready_o), 64'(i % 2 == 1));
            check("t2_rr_csr", 64'(csr_ready_o), 64'(i % 2 == 0));
            check("t2_fp_fpu", 64'(fp_fpu_ready), 64'd1);
            advance();
        end
`ifdef FPU_SS_WB_PERF_EN
        check("t2_perf_delta", 64'(perf_fpu_stall_o - perf0), 64'd2);
`else
        check("t2_perf_delta", 64'(perf_fpu_stall_o - perf0), 64'd0);
`endif
        idle();
        step();

        // 3: credits fill, FIFO fills behind a stalled output, pops release credits
        x_result_ready_i = 1'b0;
        fpu_valid_i = 1'b1;
        fpu_res_i   = mk(9, 32'h1234_5678, 1, 1'b0);
        step();
        fpu_valid_i = 1'b0;
        mem_issue_i = 1'b1;
        step();
        step();
        mem_issue_i = 1'b0;
        settle();
        check("t3_allow_full", 64'(mem_issue_allow_o), 64'd0);
        advance();
        mem_valid_i = 1'b1;
        mem_res_i   = mk(1, 32'hAAAA_0001, 2, 1'b1);
        step();
        mem_res_i   = mk(2, 32'hAAAA_0002, 3, 1'b1);
        step();
        mem_valid_i = 1'b0;
        mem_res_i   = '0;
        repeat (2) step();
        x_result_ready_i = 1'b1;
        settle();
        check("t3_pop_allow", 64'(mem_issue_allow_o), 64'd0);
        check("t3_pop_wdata", 64'(fpr_wdata_o), 64'hAAAA_0001);
        advance();
        settle();
        check("t3_x_id1", 64'(x_result_o.id), 64'd1);
        check("t3_allow_after", 64'(mem_issue_allow_o), 64'd1);
        advance();
        settle();
        check("t3_x_id2", 64'(x_result_o.id), 64'd2);
        advance();
        step();

        // 4: buffered memory result beats a waiting FPU result
        x_result_ready_i = 1'b0;
        fpu_valid_i = 1'b1;
        fpu_res_i   = mk(10, 32'h0, 4, 1'b0);
        step();
        fpu_res_i   = mk(11, 32'h4000_0000, 6, 1'b1);
        mem_issue_i = 1'b1;
        step();
        mem_issue_i = 1'b0;
        step();
        mem_valid_i = 1'b1;
        mem_res_i   = mk(7, 32'h7777_7777, 7, 1'b1);
        step();
        mem_valid_i = 1'b0;
        mem_res_i   = '0;
        x_result_ready_i = 1'b1;
        settle();
        check("t4_fpu_blocked", 64'(fpu_ready_o), 64'd0);
        advance();
        settle();
        check("t4_x_id7", 64'(x_result_o.id), 64'd7);
        check("t4_fpu_next", 64'(fpu_ready_o), 64'd1);
        advance();
        settle();
        check("t4_x_id11", 64'(x_result_o.id), 64'd11);
        advance();
        idle();
        step();

        // 5: stalled output holds; reset mid-stall
        x_result_ready_i = 1'b0;
        fpu_valid_i = 1'b1;
        fpu_res_i   = mk(12, 32'hC0DE_0012, 8, 1'b1);
        step();
        held = x_result_o;
        fpu_res_i = mk(13, 32'hC0DE_0013, 9, 1'b1);
        for (int i = 0; i < 5; i++) begin
            mem_issue_i = (i < 2);
            settle();
            check("t5_hold", 64'(x_result_o), 64'(held));
            check("t5_no_grant", 64'(fpu_ready_o), 64'd0);
            check("t5_no_fpr_we", 64'(fpr_we_o), 64'd0);
            advance();
        end
        mem_issue_i = 1'b0;
        rst_i = 1'b1;
        step();
        idle();
        settle();
        check("t5_rst_valid", 64'(x_result_valid_o), 64'd0);
        check("t5_rst_allow", 64'(mem_issue_allow_o), 64'd1);
        advance();

        // 6: stale memory result after reset is dropped
        mem_valid_i = 1'b1;
        mem_res_i   = mk(14, 32'hDEAD_BEEF, 10, 1'b1);
        step();
        mem_valid_i = 1'b0;
        mem_res_i   = '0;
        settle();
        check("t6_no_grant", 64'(fpr_we_o), 64'd0);
        check("t6_x_valid", 64'(x_result_valid_o), 64'd0);
        advance();
        mem_issue_i = 1'b1;
        step();
        step();
        mem_issue_i = 1'b0;
        settle();
        check("t6_credits_from_zero", 64'(mem_issue_allow_o), 64'd0);
        advance();
        mem_valid_i = 1'b1;
        mem_res_i   = mk(15, 32'h1, 11, 1'b0);
        step();
        mem_res_i   = mk(0, 32'h2, 12, 1'b1);
        step();
        idle();
        repeat (3) step();

        // Randomized traffic against the model
        rst_i = 1'b1;
        step();
        idle();
        pend.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst_i            = ($urandom_range(0, 249) == 0);
            fpu_valid_i      = ($urandom_range(0, 9) < 6);
            fpu_res_i        = rnd_entry();
            csr_valid_i      = ($urandom_range(0, 9) < 4);
            csr_res_i        = rnd_entry();
            x_result_ready_i = ($urandom_range(0, 9) < 7);
            mem_issue_i      = (m_credits < MEM_OUT) && ($urandom_range(0, 9) < 3);
            if (mem_issue_i) pend.push_back(cyc);
            mem_valid_i = 1'b0;
            mem_res_i   = '0;
            if (pend.size() > 0 && (cyc - pend[0]) >= 2 && $urandom_range(0, 1) == 1) begin
                void'(pend.pop_front());
                mem_valid_i = 1'b1;
                mem_res_i   = rnd_entry();
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
